// File: rtl/irq_pending_reg8_pkg.sv
// Shared constants for the irq_pending_reg8 interrupt front end.
package irq_pkg;

  localparam int unsigned NUM_IRQ = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CNT_W   = 3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

endpackage

// File: rtl/irq_pending_reg8_sync_edge.sv
// Single-line synchroniser with rising-edge detect; a line already high at
// reset release produces one edge.
module irq_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level_c,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_c = sync_q[SYNC_STAGES-1];
  assign rise_c  = level_c & ~prev_q;

endmodule

// File: rtl/irq_pending_reg8.sv
// Interrupt pending register feeding an 8-to-3 priority encoder.
// Define LEVEL_TRIG_EN for level-sensitive capture (ack then does not clear).
module irq_pending_reg8
  import irq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COOLDOWN    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       irq_in,
  input  logic [7:0]       mask,
  input  logic             ack,
  input  logic [IDX_W-1:0] ack_idx,
  output logic [7:0]       pend_out,
  output logic             enc_en,
  output logic             irq,
  output logic             ack_err
);

  logic [NUM_IRQ-1:0] level_c;
  logic [NUM_IRQ-1:0] rise_c;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] pend_d;
  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               ack_err_d;
  logic               accept_c;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .d       (irq_in[g]),
      .level_c (level_c[g]),
      .rise_c  (rise_c[g])
    );
  end

  assign pend_out = pend_q & ~mask;
  assign accept_c = (state_q == ARMED) && ack && pend_out[ack_idx];

  // Pending capture; a new edge wins over a same-cycle clear.
  always_comb begin
`ifdef LEVEL_TRIG_EN
    pend_d = level_c;
`else
    pend_d = pend_q;
    if (accept_c) pend_d[ack_idx] = 1'b0;
    pend_d = pend_d | rise_c;
`endif
  end

  // Assert / acknowledge / cool-down sequencing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ack_err_d = ack && !accept_c;
    case (state_q)
      IDLE: begin
        if (pend_out != '0) state_d = ARMED;
      end
      ARMED: begin
        if (accept_c) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(COOLDOWN);
        end else if (!ack && pend_out == '0) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = (pend_out != '0) ? ARMED : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      enc_en  <= 1'b0;
      irq     <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      enc_en  <= (state_d == ARMED);
      irq     <= (state_d == ARMED);
      ack_err <= ack_err_d;
    end
  end

endmodule

// File: tb/tb_irq_pending_reg8.sv
// Directed and randomized check of irq_pending_reg8 against a history-based model.
module tb_irq_pending_reg8;

  localparam int unsigned S  = 2;
  localparam int unsigned CD = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in, mask;
  logic       ack;
  logic [2:0] ack_idx;
  logic [7:0] pend_out;
  logic       enc_en, irq, ack_err;

  int vectors    = 0;
  int miscompares = 0;

  // Model: raw samples per edge, pending vector, mode (0 idle,1 armed,2 cooling)
  logic [7:0] h [0:4];
  logic [7:0] m_pend;
  int         m_mode;
  int         m_left;
  logic       m_err;

  irq_pending_reg8 #(.SYNC_STAGES(S), .COOLDOWN(CD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_in   (irq_in),
    .mask     (mask),
    .ack      (ack),
    .ack_idx  (ack_idx),
    .pend_out (pend_out),
    .enc_en   (enc_en),
    .irq      (irq),
    .ack_err  (ack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 5; k++) h[k] = 8'h00;
    m_pend = 8'h00;
    m_mode = 0;
    m_left = 0;
    m_err  = 1'b0;
  endtask

  task automatic model_edge();
    logic [7:0] lvl, rise, pout;
    logic       acc;
    lvl  = h[S-1];
    rise = lvl & ~h[S];
    pout = m_pend & ~mask;
    acc  = (m_mode == 1) && ack && pout[ack_idx];
    m_err = ack && !acc;
`ifdef LEVEL_TRIG_EN
    m_pend = lvl;
`else
    if (acc) m_pend[ack_idx] = 1'b0;
    m_pend = m_pend | rise;
`endif
    if (m_mode == 0) begin
      if (pout != 0) m_mode = 1;
    end else if (m_mode == 1) begin
      if (acc) begin
        m_mode = 2;
        m_left = CD;
      end else if (!ack && pout == 0) begin
        m_mode = 0;
      end
    end else begin
      m_left--;
      if (m_left == 0) m_mode = (pout != 0) ? 1 : 0;
    end
    for (int k = 4; k > 0; k--) h[k] = h[k-1];
    h[0] = irq_in;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic [7:0] i, input logic [7:0] m, input logic a, input logic [2:0] idx);
    irq_in = i; mask = m; ack = a; ack_idx = idx;
    @(posedge clk);
    model_edge();
    #1;
    check("pend_out", pend_out, m_pend & ~mask);
    check("enc_en", {7'd0, enc_en}, {7'd0, m_mode == 1});
    check("irq", {7'd0, irq}, {7'd0, m_mode == 1});
    check("ack_err", {7'd0, ack_err}, {7'd0, m_err});
    @(negedge clk);
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_pend_out", pend_out, 8'h00);
    check("rst_enc_en", {7'd0, enc_en}, 8'h00);
    check("rst_irq", {7'd0, irq}, 8'h00);
    check("rst_ack_err", {7'd0, ack_err}, 8'h00);
    model_reset();
    @(negedge clk);
    irq_in = 8'h00; mask = 8'h00; ack = 1'b0; ack_idx = 3'd0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; irq_in = 8'h00; mask = 8'h00; ack = 1'b0; ack_idx = 3'd0;
    model_reset();
    #3;
    check("reset_pend_out", pend_out, 8'h00);
    check("reset_irq", {7'd0, irq}, 8'h00);
    check("reset_enc_en", {7'd0, enc_en}, 8'h00);
    check("reset_ack_err", {7'd0, ack_err}, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle pulse on line 5: pending at edge 3, request at edge 4
    step(8'h20, 8'h00, 1'b0, 3'd0);
    step(8'h00, 8'h00, 1'b0, 3'd0);
    step(8'h00, 8'h00, 1'b0, 3'd0);
    check("lat_pend_e3", pend_out, 8'h20);
    check("lat_irq_e3", {7'd0, irq}, 8'h00);
    step(8'h00, 8'h00, 1'b0, 3'd0);
    check("lat_irq_e4", {7'd0, irq}, 8'h01);
    check("lat_en_e4", {7'd0, enc_en}, 8'h01);
    step(8'h00, 8'h00, 1'b1, 3'd5);
    step(8'h00, 8'h00, 1'b0, 3'd0);

    // Two pending, ack the higher one, short cool-down then re-arm
    step(8'h90, 8'h00, 1'b0, 3'd0);
    step(8'h90, 8'h00, 1'b0, 3'd0);
    step(8'h00, 8'h00, 1'b0, 3'd0);
    step(8'h00, 8'h00, 1'b0, 3'd0);
    step(8'h00, 8'h00, 1'b1, 3'd7);
    check("ack7_pend", pend_out, 8'h10);
    check("ack7_en_low", {7'd0, enc_en}, 8'h00);
    step(8'h00, 8'h00, 1'b0, 3'd0);
    check("ack7_rearm", {7'd0, irq}, 8'h01);
    step(8'h00, 8'h00, 1'b1, 3'd4);
    step(8'h00, 8'h00, 1'b0, 3'd0);

    // Masked capture, then unmask
    step(8'h04, 8'hFF, 1'b0, 3'd0);
    step(8'h00, 8'hFF, 1'b0, 3'd0);
    step(8'h00, 8'hFF, 1'b0, 3'd0);
    step(8'h00, 8'hFF, 1'b0, 3'd0);
    check("masked_pend", pend_out, 8'h00);
    check("masked_irq", {7'd0, irq}, 8'h00);
    step(8'h00, 8'h00, 1'b0, 3'd0);
    check("unmask_pend", pend_out, 8'h04);
    check("unmask_irq", {7'd0, irq}, 8'h01);
    step(8'h00, 8'h00, 1'b1, 3'd2);
    step(8'h00, 8'h00, 1'b0, 3'd0);

    // Ack of a non-pending index
    step(8'h01, 8'h00, 1'b0, 3'd0);
    step(8'h00, 8'h00, 1'b0, 3'd0);
    step(8'h00, 8'h00, 1'b0, 3'd0);
    step(8'h00, 8'h00, 1'b0, 3'd0);
    step(8'h00, 8'h00, 1'b1, 3'd3);
    check("bad_ack_err", {7'd0, ack_err}, 8'h01);
    check("bad_ack_pend", pend_out, 8'h01);
    check("bad_ack_irq", {7'd0, irq}, 8'h01);
    step(8'h00, 8'h00, 1'b0, 3'd0);
    check("bad_ack_pulse", {7'd0, ack_err}, 8'h00);

    // New edge on line 1 coincides with its ack: stays pending
    step(8'h02, 8'h00, 1'b1, 3'd0);
    step(8'h00, 8'h00, 1'b0, 3'd0);
    step(8'h00, 8'h00, 1'b0, 3'd0);
    step(8'h00, 8'h00, 1'b0, 3'd0);
    step(8'h02, 8'h00, 1'b0, 3'd0);
    step(8'h00, 8'h00, 1'b0, 3'd0);
    step(8'h00, 8'h00, 1'b1, 3'd1);
    check("setwins_pend", pend_out, 8'h02);
    check("setwins_en", {7'd0, enc_en}, 8'h00);
    step(8'h00, 8'h00, 1'b0, 3'd0);
    check("setwins_irq", {7'd0, irq}, 8'h01);

    // Reset in the middle of cool-down with 0x0C still pending
    step(8'h0D, 8'h00, 1'b1, 3'd1);
    step(8'h00, 8'h00, 1'b0, 3'd0);
    step(8'h00, 8'h00, 1'b0, 3'd0);
    step(8'h00, 8'h00, 1'b0, 3'd0);
    step(8'h00, 8'h00, 1'b1, 3'd0);
    check("hold_pend", pend_out, 8'h0C);
    mid_reset();
    repeat (4) step(8'h00, 8'h00, 1'b0, 3'd0);
    check("post_rst_pend", pend_out, 8'h00);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [7:0] ri, rm;
      ri = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      rm = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h00;
      step(ri, rm, ($urandom_range(0, 2) == 0), 3'($urandom));
      if (n == 300) mid_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/irq_pending_reg8.md
Name: irq_pending_reg8

Overview:
Interrupt-request front end that sits directly upstream of the 8-to-3 priority encoder. It synchronises eight asynchronous request lines, rising-edge detects them, and latches them into sticky pending bits. It presents the masked pending vector and an enable strobe to the encoder's input/enable pins. The encoder's 3-bit index comes back as an acknowledge, which clears the serviced bit; a small FSM sequences assert/acknowledge/cool-down.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per request line (legal 2..4)
COOLDOWN, 1, cycles enc_en is held low after an accepted ack (legal 1..7)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
irq_in  input  8  raw asynchronous request lines, bit 7 highest priority
mask  input  8  1 = bit hidden from encoder (still latched)
ack  input  1  one-cycle pulse: encoder index accepted by consumer
ack_idx  input  3  index being acknowledged (encoder output)
pend_out  output  8  pend_q & ~mask, drives encoder data input
enc_en  output  1  encoder enable, registered
irq  output  1  interrupt request to consumer, registered
ack_err  output  1  one-cycle pulse: ack for a non-pending or masked bit, or ack outside ARMED

Behaviour:
- Reset (async assert, sync-release usage): sync chain, prev_q, pend_q = 0; state = IDLE; enc_en = irq = ack_err = 0; pend_out = 0.
- Sync: each irq_in bit passes through SYNC_STAGES flops; edge = sync & ~prev_q; prev_q <= sync.
- Line high at reset release counts as one rising edge.
- pend_q[i] set on edge[i]; cleared by an accepted ack with ack_idx == i.
- Same-cycle set and clear on one bit: set wins, so the bit stays pending.
- Masked bits keep latching; unmasking exposes them on pend_out combinationally.
- Latency: irq_in rise -> pend_out bit after SYNC_STAGES+1 clk edges -> irq/enc_en after SYNC_STAGES+2 edges.
- FSM (registered outputs are decoded from next state):
  - IDLE: enc_en = 0, irq = 0. When pend_out != 0, go to ARMED.
  - ARMED: enc_en = 1, irq = 1.
    - On ack with pend_out[ack_idx] = 1: clear the bit and go to HOLD; cool-down counter = COOLDOWN.
    - On ack with pend_out[ack_idx] = 0: pulse ack_err, nothing cleared, stay ARMED.
    - If pend_out falls to 0 without ack (mask change): go to IDLE.
  - HOLD: enc_en = 0, irq = 0; counter decrements each cycle. At 0, go to ARMED if pend_out != 0, else IDLE.
- ack in IDLE or HOLD: ignored, ack_err pulses.
- Reset mid-operation: all state discarded immediately; edges already in the sync chain are lost.

Optional Feature:
LEVEL_TRIG_EN:
- Defined: capture is level-sensitive. pend_q[i] follows the synchronised level and ack has no clearing effect; ack still steps the FSM to HOLD and ack_err rules are unchanged. A bit whose line is still high re-raises irq after cool-down.
- Undefined: edge-triggered sticky behaviour as above.

Decomposition:
- Package irq_pkg: IDX_W = 3, NUM_IRQ = 8, state encoding IDLE = 2'd0, ARMED = 2'd1, HOLD = 2'd2, and the cool-down counter width.
- One sub-module: irq_sync_edge, a per-line synchroniser plus edge detector, instantiated 8 times via generate.

Test Plan:
- Reset with irq_in = 8'h00, release, pulse irq_in[5] for 1 cycle, defaults -> pend_out = 8'h20 at edge 3, irq = enc_en = 1 at edge 4.
- irq_in = 8'h90 pending, ack with ack_idx = 7 -> pend_out = 8'h10, enc_en low for 1 cycle, then ARMED again with irq = 1.
- mask = 8'hFF while irq_in[2] pulses -> pend_out = 0, irq = 0. Then mask = 0 -> pend_out = 8'h04, irq = 1 next cycle.
- ARMED with pend_out = 8'h01, ack with ack_idx = 3 -> ack_err single-cycle pulse, pend_out unchanged, state stays ARMED.
- New irq_in[1] edge arrives in the same cycle as ack of idx 1 -> bit 1 remains pending; irq reasserts after COOLDOWN.
- rst_n asserted mid-HOLD with pend_out = 8'h0C -> all outputs 0 asynchronously, no residual pending after release.
